// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: widths, block geometry, FSM
// state encoding and fill-target encodings.
package mem_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LAT     = 4;

  // Address split: {block base, word offset, byte-in-word offset}.
  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int BASE_W = ADDR_W - WORD_W - BYTE_W;

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

  localparam logic FILL_SEL_IC = 1'b0;
  localparam logic FILL_SEL_DC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL_ISSUE,
    ST_FILL_DRAIN
  } state_e;

  // Byte address of one word inside a block.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [BASE_W-1:0] base,
                                                  input logic [WORD_W-1:0] word);
    return {base, word, {BYTE_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side requests, memory bus and fill-steering signals.
// master: the arbiter; slave: caches plus memory model.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              ic_miss;
  logic [ADDR_W-1:0] ic_miss_addr;
  logic              dc_miss;
  logic [ADDR_W-1:0] dc_miss_addr;
  logic              dc_wr_req;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [DATA_W-1:0] dc_wr_data;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  logic              fill_we;
  logic              fill_sel;
  logic [WORD_W-1:0] fill_word;
  logic [DATA_W-1:0] fill_data;
  logic              ic_fill_done;
  logic              dc_fill_done;
  logic              wr_ack;
  logic              stall;

  modport master (
    input  ic_miss, ic_miss_addr, dc_miss, dc_miss_addr,
           dc_wr_req, dc_wr_addr, dc_wr_data, mem_rdata, mem_rvalid,
    output mem_en, mem_wr, mem_addr, mem_wdata,
           fill_we, fill_sel, fill_word, fill_data,
           ic_fill_done, dc_fill_done, wr_ack, stall
  );

  modport slave (
    output ic_miss, ic_miss_addr, dc_miss, dc_miss_addr,
           dc_wr_req, dc_wr_addr, dc_wr_data, mem_rdata, mem_rvalid,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
           fill_we, fill_sel, fill_word, fill_data,
           ic_fill_done, dc_fill_done, wr_ack, stall
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Request select for the memory arbiter. Stores always win; between the two
// miss sources the D-cache wins by default. With MEM_ARB_RR_EN defined the
// miss sources alternate on a tie using a last_grant register that starts
// at the I-cache, so the first tie goes to the D-cache.
module mem_arb_grant
  import mem_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic arb_en,
  input  logic dc_wr_req,
  input  logic dc_miss,
  input  logic ic_miss,
  output logic grant_wr,
  output logic grant_dc,
  output logic grant_ic
);

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;
  logic last_grant_d;
  logic dc_wins_tie;

  assign dc_wins_tie = (last_grant_q == FILL_SEL_IC);

  // Remember which miss side was served most recently.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_dc) last_grant_d = FILL_SEL_DC;
    else if (grant_ic) last_grant_d = FILL_SEL_IC;
  end

  // last_grant register.
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= FILL_SEL_IC;
    else     last_grant_q <= last_grant_d;
  end
`else
  logic dc_wins_tie;

  assign dc_wins_tie = 1'b1;
`endif

  // Priority select, only meaningful while the FSM can accept a request.
  always_comb begin
    grant_wr = 1'b0;
    grant_dc = 1'b0;
    grant_ic = 1'b0;
    if (arb_en) begin
      if (dc_wr_req)                 grant_wr = 1'b1;
      else if (dc_miss && ic_miss) begin
        if (dc_wins_tie)             grant_dc = 1'b1;
        else                         grant_ic = 1'b1;
      end
      else if (dc_miss)              grant_dc = 1'b1;
      else if (ic_miss)              grant_ic = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: serialises write-through stores and 8-word I/D block
// fills onto one pipelined memory port, counts in-order returns, steers them
// into the right cache and holds the pipeline stall.
// Optional MEM_ARB_RR_EN: round-robin between the two miss sources.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [WORD_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              fill_sel_q, fill_sel_d;

  logic grant_wr, grant_dc, grant_ic;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .arb_en    (state_q == ST_IDLE),
    .dc_wr_req (bus.dc_wr_req),
    .dc_miss   (bus.dc_miss),
    .ic_miss   (bus.ic_miss),
    .grant_wr  (grant_wr),
    .grant_dc  (grant_dc),
    .grant_ic  (grant_ic)
  );

  // Next-state, counters and all memory/fill outputs.
  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    ret_cnt_d        = ret_cnt_q;
    base_d           = base_q;
    fill_sel_d       = fill_sel_q;
    bus.mem_en       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.fill_we      = 1'b0;
    bus.fill_word    = '0;
    bus.fill_data    = '0;
    bus.ic_fill_done = 1'b0;
    bus.dc_fill_done = 1'b0;
    bus.wr_ack       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        if (grant_wr) begin
          state_d = ST_WRITE;
        end else if (grant_dc) begin
          state_d    = ST_FILL_ISSUE;
          base_d     = bus.dc_miss_addr[ADDR_W-1 -: BASE_W];
          fill_sel_d = FILL_SEL_DC;
        end else if (grant_ic) begin
          state_d    = ST_FILL_ISSUE;
          base_d     = bus.ic_miss_addr[ADDR_W-1 -: BASE_W];
          fill_sel_d = FILL_SEL_IC;
        end
      end

      ST_WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = bus.dc_wr_addr;
        bus.mem_wdata = bus.dc_wr_data;
        bus.wr_ack    = 1'b1;
        state_d       = ST_IDLE;
      end

      ST_FILL_ISSUE, ST_FILL_DRAIN: begin
        if (state_q == ST_FILL_ISSUE) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = word_addr(base_q, issue_cnt_q);
          issue_cnt_d  = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_WORD) state_d = ST_FILL_DRAIN;
        end
        // Returns arrive in issue order, so a running count names the word.
        if (bus.mem_rvalid) begin
          bus.fill_we   = 1'b1;
          bus.fill_word = ret_cnt_q;
          bus.fill_data = bus.mem_rdata;
          ret_cnt_d     = ret_cnt_q + 1'b1;
          if (ret_cnt_q == LAST_WORD) begin
            bus.dc_fill_done = (fill_sel_q == FILL_SEL_DC);
            bus.ic_fill_done = (fill_sel_q == FILL_SEL_IC);
            state_d          = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, latched block base and fill target.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      base_q      <= '0;
      fill_sel_q  <= FILL_SEL_IC;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      base_q      <= base_d;
      fill_sel_q  <= fill_sel_d;
    end
  end

  assign bus.fill_sel = fill_sel_q;
  assign bus.stall    = (state_q != ST_IDLE) | bus.ic_miss | bus.dc_miss | bus.dc_wr_req;

endmodule
